// File: rtl/pattern_tx_pkg.sv
// Shared types and constants for the "010"-delimited serial frame transmitter.
package pattern_tx_pkg;

  typedef enum logic [2:0] {
    IDLE, PRE0, PRE1, PRE2, DATA, STUFF, TRL0, TRL1
  } state_t;

  localparam logic [2:0] PREAMBLE  = 3'b010;
  localparam int         TRAIL_LEN = 2;
  localparam logic       IDLE_BIT  = 1'b1;

endpackage

// File: rtl/pattern_tx_shift_reg.sv
// MSB-first payload shifter; last is high while the bit on the line is the final payload bit.
module tx_shift_reg #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift,
  output logic         msb,
  output logic         last
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt counts bits still to be taken after the one currently on the line
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load) begin
      sr_d  = load_data;
      cnt_d = CW'(W);
    end else if (shift) begin
      sr_d  = {sr_q[W-2:0], 1'b0};
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign msb  = sr_q[W-1];
  assign last = (cnt_q == '0);

endmodule

// File: rtl/pattern_tx.sv
// Frame transmitter: preamble 010, bit-stuffed MSB-first payload, two-bit high trailer.
module pattern_tx
  import pattern_tx_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] data_in,
  input  logic         valid,
  output logic         ready,
  output logic         a,
  output logic         done
);

  state_t state_q, state_d;
  logic   a_q, a_d, prev_a_q, prev_a_d, done_q, done_d;
  logic   load, shift, msb, last;

  tx_shift_reg #(.W(W)) u_sr (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .load_data (data_in),
    .shift     (shift),
    .msb       (msb),
    .last      (last)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    prev_a_d = a_q;
    done_d   = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    case (state_q)
      IDLE: begin
        a_d = IDLE_BIT;
        if (valid) begin
          state_d = PRE0;
          a_d     = PREAMBLE[2];
          load    = 1'b1;
        end
      end
      PRE0: begin state_d = PRE1; a_d = PREAMBLE[1]; end
      PRE1: begin state_d = PRE2; a_d = PREAMBLE[0]; end
      PRE2: begin state_d = DATA; a_d = msb; shift = 1'b1; end
      DATA: begin
        // a 0,1 pair on the line must be followed by a 1 so 010 cannot form
        if (!prev_a_q && a_q) begin
          state_d = STUFF;
          a_d     = 1'b1;
        end else if (last) begin
          state_d = TRL0;
          a_d     = 1'b1;
        end else begin
          a_d   = msb;
          shift = 1'b1;
        end
      end
      STUFF: begin
        if (last) begin
          state_d = TRL0;
          a_d     = 1'b1;
        end else begin
          state_d = DATA;
          a_d     = msb;
          shift   = 1'b1;
        end
      end
      TRL0: begin state_d = TRL1; a_d = 1'b1; end
      TRL1: begin state_d = IDLE; a_d = IDLE_BIT; done_d = 1'b1; end
      default: begin state_d = IDLE; a_d = IDLE_BIT; end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= IDLE_BIT;
      prev_a_q <= IDLE_BIT;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      prev_a_q <= prev_a_d;
      done_q   <= done_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign a     = a_q;
  assign done  = done_q;

endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx: directed words, mid-frame reset, random back-to-back frames.
module tb_pattern_tx;
  import pattern_tx_pkg::*;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         valid;
  logic [W-1:0] data_in;
  logic         ready, a, done;

  int       checks = 0;
  int       errors = 0;
  logic [2:0] hist;
  bit       exp_q[$];

  pattern_tx #(.W(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .data_in (data_in),
    .valid   (valid),
    .ready   (ready),
    .a       (a),
    .done    (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line image of one frame built straight from the framing rules.
  function automatic void build(input logic [W-1:0] w);
    exp_q = {};
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    for (int i = W - 1; i >= 0; i--) begin
      exp_q.push_back(w[i]);
      if (exp_q[exp_q.size()-2] == 1'b0 && exp_q[exp_q.size()-1] == 1'b1)
        exp_q.push_back(1'b1);
    end
    for (int i = 0; i < TRAIL_LEN; i++) exp_q.push_back(1'b1);
  endfunction

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      hist = {hist[1:0], a};
      chk({tag, " idle a"}, a, 1);
      chk({tag, " idle ready"}, ready, 1);
      chk({tag, " idle done"}, done, 0);
    end
  endtask

  // Called at a negedge with the block idle; returns at the negedge where done is high.
  task automatic frame(input logic [W-1:0] w, input bit b2b, input string tag);
    bit obs[$];
    int dets, detpos;
    logic [W-1:0] rx;
    dets = 0; detpos = -1; rx = '0;
    build(w);
    data_in = w;
    valid   = 1'b1;
    @(posedge clock);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clock);
      if (b2b) data_in = W'($urandom);
      else     valid   = 1'b0;
      chk($sformatf("%s bit%0d", tag, i), a, exp_q[i]);
      chk($sformatf("%s ready%0d", tag, i), ready, 0);
      obs.push_back(a);
      hist = {hist[1:0], a};
      if (hist == 3'b010) begin dets++; detpos = i; end
    end
    @(negedge clock);
    hist = {hist[1:0], a};
    if (hist == 3'b010) dets++;
    chk({tag, " done"}, done, 1);
    chk({tag, " ready end"}, ready, 1);
    chk({tag, " a end"}, a, 1);
    chk({tag, " detect count"}, dets, 1);
    chk({tag, " detect pos"}, detpos, 2);
    // receiver view: drop preamble/trailer and any 1 that follows a 0,1 pair
    for (int j = 3; j < obs.size() - TRAIL_LEN; j++)
      if (!(obs[j-2] == 1'b0 && obs[j-1] == 1'b1)) rx = {rx[W-2:0], obs[j]};
    chk({tag, " destuffed"}, rx, w);
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; data_in = '0; hist = 3'b111;
    repeat (2) @(negedge clock);
    chk("reset a", a, 1);
    chk("reset ready", ready, 1);
    chk("reset done", done, 0);
    reset = 1'b0;
    idle(2, "post reset");

    // abort a frame in DATA with an asynchronous reset
    data_in = 8'hAA; valid = 1'b1;
    @(posedge clock);
    @(negedge clock); valid = 1'b0;
    chk("abort pre0", a, 0);
    repeat (3) @(negedge clock);
    chk("abort in data ready", ready, 0);
    #2 reset = 1'b1;
    #1;
    chk("abort a", a, 1);
    chk("abort ready", ready, 1);
    chk("abort done", done, 0);
    @(negedge clock); reset = 1'b0; hist = 3'b111;
    idle(3, "after abort");

    frame(8'h00, 1'b0, "w00"); chk("len 00", exp_q.size(), 13); idle(1, "w00");
    frame(8'hFF, 1'b0, "wFF"); chk("len FF", exp_q.size(), 14); idle(1, "wFF");
    frame(8'hAA, 1'b0, "wAA"); chk("len AA", exp_q.size(), 17); idle(1, "wAA");
    frame(8'h55, 1'b0, "w55"); chk("len 55", exp_q.size(), 17); idle(2, "w55");

    for (int n = 0; n < 20; n++) frame(W'($urandom), 1'b1, $sformatf("b2b%0d", n));
    valid = 1'b0;
    idle(2, "end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
